// File: rtl/mov_imm_sequencer.sv
// Purpose: turn a 64-bit constant into the LEGv8 MOVZ/MOVK sequence that rebuilds it in a register.
// Latency: an accepted constant presents word 1 in the next cycle, then one word per cycle.
// Backpressure: out_ready low holds out_instr/out_last/out_count; in_ready is low for the whole sequence.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   resetl     in   1   asynchronous active-low reset
//   in_valid   in   1   a constant is offered
//   in_ready   out  1   block is idle and will accept a constant
//   in_value   in   64  constant to materialise
//   in_rd      in   5   destination register number
//   out_valid  out  1   out_instr holds a valid instruction
//   out_ready  in   1   consumer takes out_instr this cycle
//   out_instr  out  32  {opc9, hw[1:0], imm16, rd[4:0]}
//   out_last   out  1   current word is the final one of the sequence
//   out_count  out  3   words in the current sequence (1..4), 0 when idle
//
// EMIT_ALL=1 always emits MOVZ hw0 followed by MOVK hw1..3; EMIT_ALL=0 skips
// zero 16-bit chunks (an all-zero constant still produces a single MOVZ #0).

module mov_imm_sequencer #(
  parameter bit EMIT_ALL = 1'b0
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic [2:0]  out_count
);

  localparam logic [8:0] OPC_MOVZ = 9'b110100101;
  localparam logic [8:0] OPC_MOVK = 9'b111100101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched request and the ordered list of hw slots to emit.
  // r_list packs up to four 2-bit hw numbers, entry i at bits [2i+1:2i].
  logic [63:0] r_value;
  logic [4:0]  r_rd;
  logic [7:0]  r_list;
  logic [1:0]  r_idx;
  logic [2:0]  r_count;
  logic [31:0] r_instr;
  logic        r_last;

  logic [3:0]  w_mask;
  logic [7:0]  w_list;
  logic [2:0]  w_cnt;
  logic        w_load;
  logic        w_adv;
  logic        w_done;
  logic [1:0]  w_idx_nxt;
  logic [1:0]  w_hw_nxt;

  // Build one instruction word for slot hw of value.
  function automatic logic [31:0] f_encode(
    input logic        is_movz,
    input logic [1:0]  hw,
    input logic [63:0] value,
    input logic [4:0]  rd
  );
    logic [15:0] imm;
    case (hw)
      2'd0:    imm = value[15:0];
      2'd1:    imm = value[31:16];
      2'd2:    imm = value[47:32];
      default: imm = value[63:48];
    endcase
    f_encode = {(is_movz ? OPC_MOVZ : OPC_MOVK), hw, imm, rd};
  endfunction

  // Nonzero-chunk mask of the offered constant.
  always_comb begin
    w_mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_mask[k] = |in_value[16*k +: 16];
    end
  end

  // Compact the mask into an ascending hw list; an empty mask degenerates
  // to slot 0 alone so the register is still written (MOVZ #0).
  always_comb begin
    w_list = 8'h00;
    w_cnt  = 3'd0;
    if (EMIT_ALL) begin
      w_list = {2'd3, 2'd2, 2'd1, 2'd0};
      w_cnt  = 3'd4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_mask[k]) begin
          w_list[{w_cnt[1:0], 1'b0} +: 2] = 2'(k);
          w_cnt = w_cnt + 3'd1;
        end
      end
      if (w_cnt == 3'd0) begin
        w_cnt = 3'd1;
      end
    end
  end

  assign w_idx_nxt = r_idx + 2'd1;
  assign w_hw_nxt  = r_list[{w_idx_nxt, 1'b0} +: 2];

  // State register.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        // in_valid is deliberately ignored here.
        if (out_ready) begin
          if (r_last) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: the word for the next slot is precomputed at the handshake
  // edge so out_instr is always a flop output.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_value <= 64'd0;
      r_rd    <= 5'd0;
      r_list  <= 8'h00;
      r_idx   <= 2'd0;
      r_count <= 3'd0;
      r_instr <= 32'd0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_value <= in_value;
      r_rd    <= in_rd;
      r_list  <= w_list;
      r_idx   <= 2'd0;
      r_count <= w_cnt;
      r_instr <= f_encode(1'b1, w_list[1:0], in_value, in_rd);
      r_last  <= (w_cnt == 3'd1);
    end else if (w_adv) begin
      r_idx   <= w_idx_nxt;
      r_instr <= f_encode(1'b0, w_hw_nxt, r_value, r_rd);
      r_last  <= ({1'b0, w_idx_nxt} == (r_count - 3'd1));
    end else if (w_done) begin
      // Back to idle: count reads 0 and no stale word is left on the bus.
      r_idx   <= 2'd0;
      r_count <= 3'd0;
      r_instr <= 32'd0;
      r_last  <= 1'b0;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out_instr = r_instr;
  assign out_last  = r_last;
  assign out_count = r_count;

endmodule

// File: tb/tb_mov_imm_sequencer.sv
// Purpose: self-checking bench for mov_imm_sequencer with EMIT_ALL=0 (dut0) and EMIT_ALL=1 (dut1).
// Latency: a per-cycle model check at each falling edge, plus literal word checks per case.
// Backpressure: out_ready is driven per DUT; one case stalls the first word for three cycles.

module tb_mov_imm_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]        resetl    = 2'b00;
  logic [1:0]        in_valid  = 2'b00;
  logic [1:0][63:0]  in_value  = '0;
  logic [1:0][4:0]   in_rd     = '0;
  logic [1:0]        out_ready = 2'b11;
  wire  [1:0]        in_ready;
  wire  [1:0]        out_valid;
  wire  [1:0][31:0]  out_instr;
  wire  [1:0]        out_last;
  wire  [1:0][2:0]   out_count;

  mov_imm_sequencer #(.EMIT_ALL(1'b0)) dut0 (
    .CLK(CLK), .resetl(resetl[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_value(in_value[0]), .in_rd(in_rd[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_instr(out_instr[0]), .out_last(out_last[0]), .out_count(out_count[0])
  );

  mov_imm_sequencer #(.EMIT_ALL(1'b1)) dut1 (
    .CLK(CLK), .resetl(resetl[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_value(in_value[1]), .in_rd(in_rd[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_instr(out_instr[1]), .out_last(out_last[1]), .out_count(out_count[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per DUT: expected word list of the sequence in flight.
  bit                busy  [2];
  logic [3:0][31:0]  exp_w [2];
  int                exp_n [2];
  int                exp_i [2];

  // Every word the DUT handed over, in order.
  logic [31:0]       log_w [2][64];
  int                log_n [2];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, want %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Sequence as plain arithmetic: base opcode word + hw*2^21 + imm*2^5 + rd.
  function automatic void build_seq(input logic [63:0] v, input logic [4:0] rd, input bit all,
                                    output logic [3:0][31:0] w, output int n);
    logic [63:0] chunk;
    w = '0;
    n = 0;
    for (int hw = 0; hw < 4; hw++) begin
      chunk = (v >> (16 * hw)) & 64'hFFFF;
      if (all || chunk != 64'd0) begin
        w[n] = ((n == 0) ? 32'hD280_0000 : 32'hF280_0000)
               + 32'(hw * (1 << 21)) + 32'(chunk * 32) + 32'(rd);
        n++;
      end
    end
    if (n == 0) begin
      w[0] = 32'hD280_0000 + 32'(rd);
      n = 1;
    end
  endfunction

  // Compare current outputs with the model, then advance the model to
  // what the next rising edge will do with the inputs now applied.
  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      if (!resetl[d]) begin
        chk("rst_in_ready",  d, 64'(in_ready[d]),  64'd1);
        chk("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
        chk("rst_out_instr", d, 64'(out_instr[d]), 64'd0);
        chk("rst_out_last",  d, 64'(out_last[d]),  64'd0);
        chk("rst_out_count", d, 64'(out_count[d]), 64'd0);
        busy[d] = 1'b0;
      end else begin
        chk("in_ready",  d, 64'(in_ready[d]),  64'(!busy[d]));
        chk("out_valid", d, 64'(out_valid[d]), 64'(busy[d]));
        if (busy[d]) begin
          chk("out_instr", d, 64'(out_instr[d]), 64'(exp_w[d][exp_i[d]]));
          chk("out_last",  d, 64'(out_last[d]),  64'(exp_i[d] == exp_n[d] - 1));
          chk("out_count", d, 64'(out_count[d]), 64'(exp_n[d]));
          if (out_ready[d]) begin
            if (log_n[d] < 64) log_w[d][log_n[d]] = out_instr[d];
            log_n[d]++;
            exp_i[d]++;
            if (exp_i[d] == exp_n[d]) busy[d] = 1'b0;
          end
        end else begin
          chk("idle_out_count", d, 64'(out_count[d]), 64'd0);
          if (in_valid[d]) begin
            build_seq(in_value[d], in_rd[d], (d == 1), exp_w[d], exp_n[d]);
            exp_i[d] = 0;
            busy[d]  = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: check at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  // Offer one constant for one cycle; returns in cycle 1 of the sequence.
  task automatic send(input int d, input logic [63:0] v, input logic [4:0] rd);
    in_valid[d] = 1'b1;
    in_value[d] = v;
    in_rd[d]    = rd;
    step();
    in_valid[d] = 1'b0;
  endtask

  // Send with out_ready high and compare the handed-over words to literals
  // (element 0 in the low 32 bits).
  task automatic run_case(input string name, input int d, input logic [63:0] v, input logic [4:0] rd,
                          input int n, input logic [3:0][31:0] lit);
    int base;
    base = log_n[d];
    send(d, v, rd);
    repeat (6) step();
    chk({name, "_words"}, d, 64'(log_n[d] - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk({name, "_lit"}, d, 64'(log_w[d][base + i]), 64'(lit[i]));
    end
  endtask

  initial begin
    logic [3:0][31:0] mw;
    int               mn;
    int               base;

    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; exp_n[d] = 0; exp_i[d] = 0; log_n[d] = 0; exp_w[d] = '0;
    end

    // Pin the model on the sparse and all-ones constants.
    build_seq(64'h1234_0000_0000_5678, 5'd2, 1'b0, mw, mn);
    chk("model_sparse_n",  0, 64'(mn),    64'd2);
    chk("model_sparse_w0", 0, 64'(mw[0]), 64'hD28A_CF02);
    chk("model_sparse_w1", 0, 64'(mw[1]), 64'hF2E2_4682);
    build_seq(64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1, mw, mn);
    chk("model_all_n",  1, 64'(mn),    64'd4);
    chk("model_all_w3", 1, 64'(mw[3]), 64'hF2FF_FFFF);

    // Reset held: outputs at reset values (monitor checks each cycle).
    #1;
    repeat (3) step();
    resetl = 2'b11;
    step();

    // Zero constant: one MOVZ #0, in_ready back the cycle after.
    base = log_n[0];
    send(0, 64'd0, 5'd9);
    chk("zero_valid", 0, 64'(out_valid[0]), 64'd1);
    chk("zero_instr", 0, 64'(out_instr[0]), 64'hD280_0009);
    chk("zero_last",  0, 64'(out_last[0]),  64'd1);
    chk("zero_count", 0, 64'(out_count[0]), 64'd1);
    step();
    chk("zero_turn_ready", 0, 64'(in_ready[0]),  64'd1);
    chk("zero_turn_valid", 0, 64'(out_valid[0]), 64'd0);
    repeat (3) step();
    chk("zero_words", 0, 64'(log_n[0] - base), 64'd1);

    run_case("low",    0, 64'h0000_0000_0000_1234, 5'd1, 1, {32'h0, 32'h0, 32'h0, 32'hD282_4681});
    run_case("sparse", 0, 64'h1234_0000_0000_5678, 5'd2, 2, {32'h0, 32'h0, 32'hF2E2_4682, 32'hD28A_CF02});

    // Sparse again with the first word stalled for three cycles and a new
    // constant pulsed meanwhile.
    base = log_n[0];
    out_ready[0] = 1'b0;
    send(0, 64'h1234_0000_0000_5678, 5'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_instr",    0, 64'(out_instr[0]), 64'hD28A_CF02);
      chk("bp_in_ready", 0, 64'(in_ready[0]),  64'd0);
      chk("bp_count",    0, 64'(out_count[0]), 64'd2);
      in_valid[0] = (i == 0);
      in_value[0] = 64'hDEAD_BEEF_CAFE_F00D;
      in_rd[0]    = 5'd7;
      step();
    end
    out_ready[0] = 1'b1;
    repeat (6) step();
    chk("bp_words", 0, 64'(log_n[0] - base), 64'd2);
    chk("bp_w0",    0, 64'(log_w[0][base]),     64'hD28A_CF02);
    chk("bp_w1",    0, 64'(log_w[0][base + 1]), 64'hF2E2_4682);

    run_case("high", 0, 64'h0000_ABCD_0000_0000, 5'd0, 1, {32'h0, 32'h0, 32'h0, 32'hD2D5_79A0});

    run_case("all", 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 4,
             {32'hF2FF_FFFF, 32'hF2DF_FFFF, 32'hF2BF_FFFF, 32'hD29F_FFFF});

    // Abort after word 2 with a reset.
    base = log_n[1];
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
    step();
    step();
    chk("abort_pre_instr", 1, 64'(out_instr[1]), 64'hF2DF_FFFF);
    resetl[1] = 1'b0;
    #1;
    chk("abort_valid",    1, 64'(out_valid[1]), 64'd0);
    chk("abort_in_ready", 1, 64'(in_ready[1]),  64'd1);
    chk("abort_count",    1, 64'(out_count[1]), 64'd0);
    step();
    step();
    resetl[1] = 1'b1;
    repeat (5) step();
    chk("abort_words", 1, 64'(log_n[1] - base), 64'd2);
    chk("abort_w0",    1, 64'(log_w[1][base]),     64'hD29F_FFFF);
    chk("abort_w1",    1, 64'(log_w[1][base + 1]), 64'hF2BF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mov_imm_sequencer.md
# mov_imm_sequencer

Converts a 64-bit constant into the LEGv8 MOVZ/MOVK instruction sequence that rebuilds it in a destination register, emitting one 32-bit instruction word per handshake. It is the encode-side counterpart of the datapath's immediate extension, where the MOVZ path expands `Imm26[20:5]` shifted by `hw*16`. It sits in the assembler/loader path ahead of instruction memory. It also serves as a golden-stimulus source for MOVZ/MOVK tests of the single-cycle processor.

## Interface
- `EMIT_ALL`, default 0: when 1, always emit four instructions (MOVZ hw=0, then MOVK hw=1,2,3). When 0, skip zero 16-bit chunks.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `resetl`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a constant is offered.
- `in_ready`  out  1  block can accept a constant.
- `in_value`  in  64  constant to materialise.
- `in_rd`  in  5  destination register number.
- `out_valid`  out  1  `out_instr` holds a valid instruction.
- `out_ready`  in  1  consumer takes `out_instr` this cycle.
- `out_instr`  out  32  encoded MOVZ/MOVK word.
- `out_last`  out  1  the current word is the final one of the sequence.
- `out_count`  out  3  total words in the current sequence (1..4); 0 when idle.

## Operation
- States: IDLE and EMIT.
- **IDLE**
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&`in_ready`: latch `in_value` and `in_rd`, build the 4-bit nonzero-chunk mask (chunk k = `value[16k+15:16k]`), load the emit list, and go to EMIT.
- **Emit list, `EMIT_ALL`=0**
  - Nonzero chunks in ascending hw order.
  - If all chunks are zero, the list is chunk 0 alone (MOVZ of 0).
- **Emit list, `EMIT_ALL`=1:** hw 0,1,2,3 in that order.
- **Opcode selection:** the first listed chunk is encoded as MOVZ, every later one as MOVK.
- **Encoding:** `out_instr` = {opc9, hw[1:0], imm16, rd[4:0]}.
  - MOVZ opc9 = 9'b110100101 (0xD28 base). MOVK opc9 = 9'b111100101 (0xF28 base).
  - imm16 = chunk hw of the latched value.
- **`out_count`:** popcount of the mask (forced to 1 if the mask is zero), or 4 when `EMIT_ALL`=1. Held for the whole sequence.
- **Advance in EMIT:** advance to the next listed chunk on `out_valid`&`out_ready`.
- **End of sequence:** the handshake on the word with `out_last`=1 returns the block to IDLE.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_instr`, `out_last` and `out_count` hold stable.
- **Input handling outside IDLE:** `in_valid` is ignored while in EMIT. Latched data is unaffected by later changes on `in_value` or `in_rd`.

## Timing
- **Reset values:**
  - State = IDLE, so `in_ready`=1.
  - `out_valid`=0, `out_instr`=0, `out_last`=0, `out_count`=0.
  - Latched value, rd and the chunk pointer are all 0.
- **Reset mid-sequence:** the sequence is aborted and no further words are emitted. The block is IDLE immediately on `resetl` low.
- **Latency:** an input accepted on edge 0 gives `out_valid`=1 with word 1 after that edge (registered).
- **Throughput:** one word per cycle while `out_ready`=1.
- **Turnaround (N-word sequence, `out_ready` held high):**
  - Words are presented in cycles 1..N.
  - The final handshake occurs at edge N, and `in_ready`=1 in cycle N+1.
  - There is no same-cycle output-to-input overlap.
- **Word-level flag rules:**
  - Single-word sequence: `out_last`=1 on that word.
  - `out_last` is never 1 on a word that is not the final one.
- **Outputs are registered:** no combinational path from `out_ready` to `out_instr`. `in_ready` is decoded from state only.

## Test plan
- **Reset and zero constant**
  - Hold `resetl`=0 and check all output reset values.
  - Release, then send value 0, rd=9: exactly one word 0xD2800009 with `out_last`=1 and `out_count`=1. `in_ready` returns the cycle after.
- **Single low chunk:** value 0x0000_0000_0000_1234, rd=1 → 0xD2824681, `out_last`=1.
- **Sparse chunks:** value 0x1234_0000_0000_5678, rd=2 → 0xD28ACF02, then 0xF2E24682 (`out_last` on the second), `out_count`=2.
- **Backpressure on sparse chunks**
  - Repeat the sparse-chunk case with `out_ready`=0 for 3 cycles on the first word.
  - Required: word 0xD28ACF02 holds stable, `in_ready`=0, and a pulse on `in_valid` with a new value is ignored.
  - Sequence then completes unchanged.
- **High-only chunk:** value 0x0000_ABCD_0000_0000, rd=0 → single MOVZ 0xD2D579A0.
- **`EMIT_ALL`=1 and mid-sequence reset**
  - Value 0xFFFF_FFFF_FFFF_FFFF, rd=31 → 0xD29FFFFF, 0xF2BFFFFF, 0xF2DFFFFF, 0xF2FFFFFF in consecutive cycles.
  - Assert `resetl`=0 after word 2: required `out_valid`=0 at once, no further words, and `in_ready`=1.
